wr_logic: RTL and testbench
===========================

Name: wr_logic

Overview:
Write-side pointer and flag logic for the asynchronous FIFO, running entirely in the write clock domain. It is the write-side counterpart of the read-side pointer block.
- Keeps the binary write pointer, which addresses the dual-port memory.
- Publishes a registered Gray write pointer for the read-domain synchronizer.
- Synchronizes the read-domain Gray pointer into wr_clk.
- Produces registered full, almost_full and fill-level outputs.

Parameters:
ADDR_SIZE, 4, memory address width; FIFO depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
AF_THRESH, 12, fill level at or above which almost_full asserts; legal range 1..2**ADDR_SIZE.

Ports:
wr_clk  input  1  write-domain clock; all state updates on its rising edge.
wr_rst_n  input  1  asynchronous active-low reset; synchronous deassertion is provided by the system.
wr_en  input  1  write request from the producer.
rd_ptr_gray  input  ADDR_SIZE+1  Gray read pointer, registered in the read domain (async to wr_clk).
wr_ptr  output  ADDR_SIZE  memory write address, equal to wbin[ADDR_SIZE-1:0].
wr_inc  output  1  memory write strobe, equal to wr_en & ~full (combinational).
wr_ptr_gray  output  ADDR_SIZE+1  registered Gray write pointer, sent to the read domain.
full  output  1  registered full flag.
almost_full  output  1  registered, level >= AF_THRESH.
wr_level  output  ADDR_SIZE+1  registered pessimistic fill count, range 0..2**ADDR_SIZE.

Behaviour:
- Reset (wr_rst_n=0, async): wbin, wr_ptr_gray, both sync stages, wr_level = 0; full = 0; almost_full = 0.
- wbin_next = wbin + wr_inc, modulo 2**(ADDR_SIZE+1). wgray_next = binary_to_gray(wbin_next).
- Every rising edge: wbin <= wbin_next; wr_ptr_gray <= wgray_next.
- Write accepted only when wr_inc = 1. wr_en while full: no pointer change, no memory strobe, data dropped.
- Sync stage: wq1 <= rd_ptr_gray; wq2 <= wq1. Two flops, no logic between them.
- full_val = (wgray_next == {~wq2[ADDR_SIZE:ADDR_SIZE-1], wq2[ADDR_SIZE-2:0]}). full <= full_val.
- full asserts on the edge that accepts the 2**ADDR_SIZE-th unread word; no over-write is possible.
- rbin_s = gray_to_binary(wq2). level_next = wbin_next - rbin_s, modulo 2**(ADDR_SIZE+1).
- Register updates from level_next: wr_level <= level_next; almost_full <= (level_next >= AF_THRESH).
- Read-side release latency: a change on rd_ptr_gray affects full, wr_level and almost_full after at most 3 wr_clk edges (2 sync + 1 flag register).
- Flags are pessimistic: full/level may lag a read, but never lag a write.
- Wrap-around: the MSB of the pointers distinguishes full from empty. Level stays correct across the 2**(ADDR_SIZE+1) wrap.
- Simultaneous write accepted and read observed on the same edge: level_next reflects both. full clears if the read makes room, even with a write on that edge.
- Reset mid-operation: all state returns to reset values immediately. Read-domain reset is coordinated at system level.

Optional Feature:
Macro FIFO_WR_OVF_EN.
- Defined:
  - Adds input ovf_clr (1) and output overflow (1), reset 0.
  - overflow <= 1 on any edge with wr_en & full.
  - Sticky until an edge with ovf_clr=1 and no new overflow; a new overflow on the same edge as ovf_clr wins.
- Undefined: neither port exists and no logic is generated.

Decomposition:
- Shared package fifo_pkg: ADDR_SIZE default, ptr width constant (ADDR_SIZE+1), gray_to_binary function.
- Reuse the existing binary_to_gray module for wgray_next.
- One sub-module: sync_r2w, a parameterized 2-flop synchronizer (width ADDR_SIZE+1, async active-low reset to 0). It will be reused later for sync_w2r.

Test Plan:
- Reset, ADDR_SIZE=4, AF_THRESH=12, rd_ptr_gray=0 -> full=0, almost_full=0, wr_level=0, wr_ptr=0, wr_ptr_gray=0.
- 16 consecutive writes with rd_ptr_gray=0 -> wr_level counts 1..16; almost_full rises on the edge of the 12th write; full rises on the edge of the 16th; wr_ptr_gray=5'b11000.
- While full, hold wr_en=1 for 5 cycles -> wr_inc=0, wr_ptr stays 0, wr_level stays 16. With FIFO_WR_OVF_EN, overflow=1 until ovf_clr.
- From full, set rd_ptr_gray=binary_to_gray(1) -> full=0 and wr_level=15 by the 3rd wr_clk edge, not before the 2nd.
- Pointer wrap: 40 writes interleaved with reads tracking at lag 3 -> wr_level stays 3, full never asserts, wbin wraps 31->0 cleanly.
- Assert wr_rst_n low mid-burst between clock edges -> all outputs return to reset values immediately. The first write after release gives wr_ptr=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width, pointer width
// and the Gray-to-binary conversion used by both pointer domains.
package fifo_pkg;

   localparam int FIFO_ADDR_SIZE = 4;
   localparam int FIFO_PTR_W     = FIFO_ADDR_SIZE + 1;

   typedef logic [FIFO_PTR_W-1:0] ptr_t;

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic ptr_t gray_to_binary(input ptr_t g);
      ptr_t b;
      b[FIFO_PTR_W-1] = g[FIFO_PTR_W-1];
      for (int i = FIFO_PTR_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary to reflected-Gray conversion.
module binary_to_gray #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] bin_i,
   output logic [WIDTH-1:0] gray_o
);

   assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/sync_r2w.sv
// Two-flop synchronizer for a Gray pointer crossing into another clock.
module sync_r2w #(
   parameter int WIDTH = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q1_q;
   logic [WIDTH-1:0] q2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q1_q <= '0;
         q2_q <= '0;
      end else begin
         q1_q <= d_i;
         q2_q <= q1_q;
      end
   end

   assign q_o = q2_q;

endmodule

// File: rtl/wr_logic.sv
// Async-FIFO write-side pointer, full/almost_full and level logic.
// Optional sticky overflow flag when FIFO_WR_OVF_EN is defined.
module wr_logic
   import fifo_pkg::*;
#(
   parameter int ADDR_SIZE = FIFO_ADDR_SIZE,
   parameter int AF_THRESH = 12
) (
   input  logic                 wr_clk,
   input  logic                 wr_rst_n,
   input  logic                 wr_en,
   input  logic [ADDR_SIZE:0]   rd_ptr_gray,
`ifdef FIFO_WR_OVF_EN
   input  logic                 ovf_clr,
   output logic                 overflow,
`endif
   output logic [ADDR_SIZE-1:0] wr_ptr,
   output logic                 wr_inc,
   output logic [ADDR_SIZE:0]   wr_ptr_gray,
   output logic                 full,
   output logic                 almost_full,
   output logic [ADDR_SIZE:0]   wr_level
);

   localparam int PW = ADDR_SIZE + 1;

   logic [PW-1:0] wbin_q;
   logic [PW-1:0] wbin_d;
   logic [PW-1:0] wgray_q;
   logic [PW-1:0] wgray_d;
   logic [PW-1:0] wq2;
   logic [PW-1:0] rbin_s;
   logic [PW-1:0] full_cmp;
   logic [PW-1:0] level_q;
   logic [PW-1:0] level_d;
   logic          full_q;
   logic          full_d;
   logic          af_q;
   logic          af_d;
   logic          inc;

   assign inc    = wr_en & ~full_q;
   assign wbin_d = wbin_q + PW'(inc);

   binary_to_gray #(
      .WIDTH (PW)
   ) u_b2g (
      .bin_i  (wbin_d),
      .gray_o (wgray_d)
   );

   sync_r2w #(
      .WIDTH (PW)
   ) u_sync (
      .clk_i  (wr_clk),
      .rst_ni (wr_rst_n),
      .d_i    (rd_ptr_gray),
      .q_o    (wq2)
   );

   // Full when the next write pointer has lapped the read pointer:
   // in Gray code that is the top two bits inverted, rest equal.
   always_comb begin
      rbin_s   = PW'(gray_to_binary(ptr_t'(wq2)));
      level_d  = wbin_d - rbin_s;
      full_cmp = {~wq2[PW-1:PW-2], wq2[PW-3:0]};
      full_d   = (wgray_d == full_cmp);
      af_d     = (level_d >= PW'(AF_THRESH));
   end

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         level_q <= level_d;
         full_q  <= full_d;
         af_q    <= af_d;
      end
   end

`ifdef FIFO_WR_OVF_EN
   logic ovf_q;
   logic ovf_d;

   // A fresh overflow beats a clear on the same edge.
   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr) begin
         ovf_d = 1'b0;
      end
      if (wr_en & full_q) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign overflow = ovf_q;
`endif

   assign wr_ptr      = wbin_q[ADDR_SIZE-1:0];
   assign wr_inc      = inc;
   assign wr_ptr_gray = wgray_q;
   assign full        = full_q;
   assign almost_full = af_q;
   assign wr_level    = level_q;

endmodule

// File: tb/tb_wr_logic.sv
// Self-checking bench for wr_logic: directed scenarios plus random
// traffic against a count-based reference model.
module tb_wr_logic;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [4:0] rd_ptr_gray;
   logic [3:0] wr_ptr;
   logic       wr_inc;
   logic [4:0] wr_ptr_gray;
   logic       full;
   logic       almost_full;
   logic [4:0] wr_level;
`ifdef FIFO_WR_OVF_EN
   logic       ovf_clr;
   logic       overflow;
`endif

   wr_logic #(
      .ADDR_SIZE (4),
      .AF_THRESH (12)
   ) dut (
      .wr_clk      (clk),
      .wr_rst_n    (rst_n),
      .wr_en       (wr_en),
      .rd_ptr_gray (rd_ptr_gray),
`ifdef FIFO_WR_OVF_EN
      .ovf_clr     (ovf_clr),
      .overflow    (overflow),
`endif
      .wr_ptr      (wr_ptr),
      .wr_inc      (wr_inc),
      .wr_ptr_gray (wr_ptr_gray),
      .full        (full),
      .almost_full (almost_full),
      .wr_level    (wr_level)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // Model: total words written / read as plain integers; the read
   // count becomes visible to the writer two edges after presentation.
   int w;
   int r;
   int hist[$];
   int lvl;
   bit fm;
   bit afm;
   bit ovfm;

   function automatic int gray(input int x);
      int m;
      m = x % 32;
      return m ^ (m >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      w    = 0;
      r    = 0;
      hist = {0, 0};
      lvl  = 0;
      fm   = 1'b0;
      afm  = 1'b0;
      ovfm = 1'b0;
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, ".wr_ptr"}, 32'(wr_ptr), 32'(w % 16));
      chk({tag, ".gray"}, 32'(wr_ptr_gray), 32'(gray(w)));
      chk({tag, ".full"}, 32'(full), 32'(fm));
      chk({tag, ".af"}, 32'(almost_full), 32'(afm));
      chk({tag, ".level"}, 32'(wr_level), 32'(lvl));
`ifdef FIFO_WR_OVF_EN
      chk({tag, ".ovf"}, 32'(overflow), 32'(ovfm));
`endif
   endtask

   task automatic step(input bit we, input int rnew, input bit clr,
                       input string tag);
      bit acc;
      wr_en       = we;
      rd_ptr_gray = 5'(gray(rnew));
`ifdef FIFO_WR_OVF_EN
      ovf_clr     = clr;
`endif
      r = rnew;
      #1;
      acc = we && !fm;
      chk({tag, ".wr_inc"}, 32'(wr_inc), 32'(acc));
      @(posedge clk);
      #1;
      hist.push_back(r);
      if (hist.size() > 3) void'(hist.pop_front());
      if (we && fm) ovfm = 1'b1;
      else if (clr) ovfm = 1'b0;
      if (acc) w++;
      lvl = w - hist[0];
      fm  = (lvl == 16);
      afm = (lvl >= 12);
      chk_outputs(tag);
   endtask

   initial begin
      rst_n       = 1'b0;
      wr_en       = 1'b0;
      rd_ptr_gray = '0;
`ifdef FIFO_WR_OVF_EN
      ovf_clr     = 1'b0;
`endif
      model_reset();
      #12;
      chk_outputs("reset");
      rst_n = 1'b1;

      // Fill from empty.
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 0, 1'b0, "fill");
         if (i == 11) chk("af_before12", 32'(almost_full), 32'(0));
         if (i == 12) chk("af_at12", 32'(almost_full), 32'(1));
         if (i == 15) chk("full_before16", 32'(full), 32'(0));
      end
      chk("full_at16", 32'(full), 32'(1));
      chk("gray_at16", 32'(wr_ptr_gray), 32'(5'b11000));

      // Writes while full are dropped.
      for (int i = 0; i < 5; i++) step(1'b1, 0, 1'b0, "hold");
      chk("hold_level", 32'(wr_level), 32'(16));
      step(1'b0, 0, 1'b1, "ovfclr");

      // Read release latency.
      step(1'b0, 1, 1'b0, "rel1");
      chk("rel1_full", 32'(full), 32'(1));
      step(1'b0, 1, 1'b0, "rel2");
      step(1'b0, 1, 1'b0, "rel3");
      chk("rel3_full", 32'(full), 32'(0));
      chk("rel3_level", 32'(wr_level), 32'(15));

      // Drain, then stream with reader keeping pace across the wrap.
      while (r < w) step(1'b0, r + 1, 1'b0, "drain");
      for (int i = 0; i < 40; i++) step(1'b1, w, 1'b0, "wrap");
      chk("wrap_level", 32'(wr_level), 32'(3));

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         int rn;
         rn = r;
         if (rn < w && ($urandom % 3) != 0) rn++;
         step(($urandom % 4) != 0, rn, ($urandom % 8) == 0, "rand");
      end

      // Asynchronous reset mid-burst.
      for (int i = 0; i < 5; i++) step(1'b1, r, 1'b0, "burst");
      #2;
      rst_n       = 1'b0;
      wr_en       = 1'b0;
      rd_ptr_gray = '0;
      model_reset();
      #1;
      chk_outputs("async_rst");
      @(posedge clk);
      #1;
      chk_outputs("rst_hold");
      #2;
      rst_n = 1'b1;
      step(1'b1, 0, 1'b0, "post_rst");
      chk("post_rst_ptr", 32'(wr_ptr), 32'(1));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
